seq_pattern_tx: RTL
===================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter, the driving end of the serial sequence-detector interface.
- Takes a parallel WIDTH-bit pattern and a repeat count.
- Sends the pattern MSB-first, one bit per clock, the requested number of times, with a fixed idle gap between repetitions.
- data_out connects directly to the detector's data_in. It is used as a stimulus source in benches and as an on-chip pattern source.

Parameters:
- WIDTH, 4, pattern length in bits (≥2).
- CNT_W, 4, width of the repeat-count input.
- GAP, 2, number of idle cycles between repetitions (0 allowed; data_out=0 during gap).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- pattern  input  WIDTH  pattern to send, MSB sent first; latched on accepted start.
- repeat_cnt  input  CNT_W  number of repetitions; latched on accepted start.
- busy  output  1  high in every state except IDLE.
- data_out  output  1  serial bit; 0 when bit_valid=0.
- bit_valid  output  1  high in each cycle data_out carries a pattern bit.
- frame_last  output  1  high with the last (LSB) bit of each repetition.
- done  output  1  one-cycle pulse after the final bit.
- current_seq  output  WIDTH  last WIDTH bits transmitted, newest in LSB.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. All state is registered, and all outputs are decoded from registered state (Moore).
- Reset values: state=IDLE, busy=0, data_out=0, bit_valid=0, frame_last=0, done=0, current_seq=0. Internal shift register, bit counter, repeat counter and gap counter all reset to 0.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - On a rising edge with start=1: latch pattern into the shift register, load rem=repeat_cnt, clear current_seq, clear the bit counter.
  - Next state is SHIFT if repeat_cnt≠0, otherwise DONE.
- SHIFT:
  - data_out = shift_reg[WIDTH-1], bit_valid=1.
  - Each edge: shift left by 1, bit_cnt+1, current_seq <= {current_seq[WIDTH-2:0], data_out}.
  - frame_last=1 when bit_cnt==WIDTH-1.
  - On the edge ending the last bit, rem decrements. If rem becomes 0, go to DONE. Otherwise reload the shift register from the latched pattern and go to GAP (GAP>0) or stay in SHIFT (GAP=0).
- GAP: data_out=0, bit_valid=0 for exactly GAP cycles, then SHIFT.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Latency: start accepted at edge k gives the first bit on the output during cycle k+1 (sampled by the receiver at edge k+2).
- Busy duration: repeat_cnt=N>0 gives N·WIDTH + (N-1)·GAP + 1 busy cycles.
- start outside IDLE is ignored, including in the DONE cycle. The pattern and repeat_cnt inputs may change freely after acceptance.
- Boundary cases:
  - repeat_cnt=0: IDLE→DONE, done pulse, no bit_valid.
  - repeat_cnt all-ones: 2^CNT_W−1 repetitions, no wrap.
- Reset mid-operation: outputs return to reset values immediately, the frame is abandoned, and no done pulse occurs.
- Counter widths: bit_cnt is clog2(WIDTH) bits; gap_cnt is clog2(GAP+1) bits.

Decomposition:
- Package seq_pkg: state enum (IDLE, SHIFT, GAP, DONE), default WIDTH constant. The package is shared with the detector and the benches.
- One sub-module, seq_piso: parallel-in serial-out shift register with load/shift enables, providing the MSB output and the current_seq history register.
- The FSM and counters stay in the top module.

Test Plan:
1. Single repetition: pattern=4'b1011, repeat_cnt=1, start pulse.
   - Required: data_out=1,0,1,1 on 4 consecutive bit_valid cycles; frame_last on the 4th; done the next cycle; current_seq=4'b1011; busy high 5 cycles.
2. Repeats with gap: pattern=4'b0110, repeat_cnt=3, GAP=2.
   - Required: three frames 0110, each followed by 2 cycles of bit_valid=0, data_out=0 (no gap after the last frame); 12 bit_valid cycles; busy 17 cycles; exactly one done pulse.
3. Zero repeats: repeat_cnt=0.
   - Required: busy for 1 cycle, done=1 in the cycle after start, bit_valid never asserted, current_seq=0.
4. Start while busy: start with 4'b1011, repeat_cnt=2, then start with 4'b0000 during the 3rd bit and again during DONE.
   - Required: output stream is unchanged (1011,gap,1011); second and third starts have no effect.
5. Reset mid-frame: deassert reset_n during the 2nd bit.
   - Required: all outputs are 0 immediately, with no clock edge needed; after release, start with 4'b1101, repeat_cnt=1 gives stream 1101 and a done pulse.
6. Loopback: connect data_out to the detector's data_in and send its target pattern with repeat_cnt=2.
   - Required: seq_detected asserts once per frame, aligned with the frame_last bit.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default pattern width for the serial sequence interface
package seq_pkg;
    localparam int SEQ_WIDTH = 4;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/seq_piso.sv
// seq_piso: parallel-in serial-out shift register with a history of the bits shifted out
module seq_piso #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic             clr_hist,
    input  logic [WIDTH-1:0] din,
    output logic             msb,
    output logic [WIDTH-1:0] hist
);
    logic [WIDTH-1:0] sr_q, sr_d, hist_q, hist_d;
    // A load on the last bit of a frame wins over the shift, but the outgoing bit still enters the history
    always_comb begin
        sr_d   = load ? din : shift ? {sr_q[WIDTH-2:0], 1'b0} : sr_q;
        hist_d = clr_hist ? '0 : shift ? {hist_q[WIDTH-2:0], sr_q[WIDTH-1]} : hist_q;
    end
    // Shift and history registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q   <= '0;
            hist_q <= '0;
        end else begin
            sr_q   <= sr_d;
            hist_q <= hist_d;
        end
    end
    assign msb  = sr_q[WIDTH-1];
    assign hist = hist_q;
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: sends a parallel pattern MSB-first a requested number of times with idle gaps
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             busy,
    output logic             data_out,
    output logic             bit_valid,
    output logic             frame_last,
    output logic             done,
    output logic [WIDTH-1:0] current_seq
);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
    state_t           state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] pat_q, pat_d, load_val;
    logic             load, shift, clr_hist, msb, last_bit;
    assign last_bit = state_q == ST_SHIFT && bit_cnt_q == BW'(WIDTH - 1);
    // Next-state, counter and shift-register control decode
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rem_d     = rem_q;
        gap_cnt_d = gap_cnt_q;
        pat_d     = pat_q;
        load_val  = pat_q;
        load      = 1'b0;
        shift     = 1'b0;
        clr_hist  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                pat_d     = pattern;
                load_val  = pattern;
                load      = 1'b1;
                clr_hist  = 1'b1;
                rem_d     = repeat_cnt;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
                state_d   = repeat_cnt != '0 ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                shift     = 1'b1;
                bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
                if (last_bit) begin
                    rem_d   = rem_q - 1'b1;
                    load    = rem_q != CNT_W'(1);
                    state_d = rem_q == CNT_W'(1) ? ST_DONE : GAP > 0 ? ST_GAP : ST_SHIFT;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q == GW'(GAP - 1) ? '0 : gap_cnt_q + 1'b1;
                state_d   = gap_cnt_q == GW'(GAP - 1) ? ST_SHIFT : ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    // State and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rem_q     <= '0;
            gap_cnt_q <= '0;
            pat_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rem_q     <= rem_d;
            gap_cnt_q <= gap_cnt_d;
            pat_q     <= pat_d;
        end
    end
    seq_piso #(.WIDTH(WIDTH)) u_piso (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .shift   (shift),
        .clr_hist(clr_hist),
        .din     (load_val),
        .msb     (msb),
        .hist    (current_seq)
    );
    assign busy       = state_q != ST_IDLE;
    assign bit_valid  = state_q == ST_SHIFT;
    assign data_out   = bit_valid & msb;
    assign frame_last = last_bit;
    assign done       = state_q == ST_DONE;
endmodule
